// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with an 8-entry receive FIFO.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority line sampling.
module uart_rx_fifo #(
  parameter int BASIC_FREQ = 1152000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FIFO_FLUSH,
  input  logic       RXD,
  output logic [3:0] RX_FIFO_LEVEL,
  output logic [7:0] RX_FIFO_Q,
  input  logic       RX_FIFO_RD_REQ,
  output logic       RX_FRAMING_ERR,
  output logic       RX_OVERRUN,
  output logic       RX_BUSY
);

  localparam int DIV = BASIC_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  if (DIV < 8) begin : g_div_chk
    $error("uart_rx_fifo: BASIC_FREQ/BAUD_RATE must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  logic          r_sync1, r_sync2, r_rxs_d1;
  logic          w_rxs, w_smp;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_push, w_ferr;

  logic [7:0]    r_mem [8];
  logic [2:0]    r_wr_ptr, r_rd_ptr;
  logic [3:0]    r_level;
  logic [7:0]    r_q;
  logic          r_ferr, r_ovr;
  logic          w_full, w_rd_ok, w_wr_ok;

  assign w_rxs = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_rxs_d2;

  // keep one more cycle of line history for the majority vote
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_rxs_d2 <= 1'b1;
    else       r_rxs_d2 <= r_rxs_d1;
  end

  assign w_smp = (w_rxs & r_rxs_d1) | (w_rxs & r_rxs_d2) |
                 (r_rxs_d1 & r_rxs_d2);
`else
  assign w_smp = w_rxs;
`endif

  // two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxs_d1 <= 1'b1;
    end else begin
      r_sync1  <= RXD;
      r_sync2  <= r_sync1;
      r_rxs_d1 <= r_sync2;
    end
  end

  // receive FSM state and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // receive FSM next state, bit timing and frame decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs && r_rxs_d1) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_smp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_smp;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt = '0;
          if (w_smp) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full  = (r_level == 4'd8);
  assign w_rd_ok = RX_FIFO_RD_REQ && (r_level != 4'd0);
  assign w_wr_ok = w_push && (!w_full || w_rd_ok);

  // storage array; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (!FIFO_FLUSH && w_wr_ok) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers, level, read data and status pulses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_q      <= '0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_push && w_full && !w_rd_ok && !FIFO_FLUSH;
      if (FIFO_FLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 3'd1;
        if (w_rd_ok) begin
          r_rd_ptr <= r_rd_ptr + 3'd1;
          r_q      <= r_mem[r_rd_ptr];
        end
        if (w_wr_ok && !w_rd_ok)      r_level <= r_level + 4'd1;
        else if (!w_wr_ok && w_rd_ok) r_level <= r_level - 4'd1;
      end
    end
  end

  assign RX_FIFO_LEVEL  = r_level;
  assign RX_FIFO_Q      = r_q;
  assign RX_FRAMING_ERR = r_ferr;
  assign RX_OVERRUN     = r_ovr;
  assign RX_BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at DIV=120.
// Build with UART_RX_MAJORITY_EN to include the glitch-rejection case.
module tb_uart_rx_fifo;

  localparam int DIV = 120;

  logic       clk = 1'b0;
  logic       rst, flush, rxd, rd;
  logic [3:0] level;
  logic [7:0] q;
  logic       ferr, ovr, busy;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_ovr  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .CLK            (clk),
    .RESET          (rst),
    .FIFO_FLUSH     (flush),
    .RXD            (rxd),
    .RX_FIFO_LEVEL  (level),
    .RX_FIFO_Q      (q),
    .RX_FIFO_RD_REQ (rd),
    .RX_FRAMING_ERR (ferr),
    .RX_OVERRUN     (ovr),
    .RX_BUSY        (busy)
  );

  always @(negedge clk) begin
    if (ferr) n_ferr++;
    if (ovr)  n_ovr++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(DIV);
    end
    rxd = 1'b1;
    idle(DIV);
  endtask

  task automatic pop();
    rd = 1'b1;
    idle(1);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", level);
    end
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("FAIL reset_q: got %h want 00", q);
    end
    checks++;
    if ({ferr, ovr, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {ferr, ovr, busy});
    end
  endtask

  task automatic test_single();
    fork
      send_byte(8'h3C);
      begin
        repeat (600) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL single_busy: got %b want 1", busy);
        end
        repeat (542) @(posedge clk);
        #1;
        checks++;
        if (level !== 4'd0) begin
          errors++; $display("FAIL single_pre: got %0d want 0", level);
        end
        @(posedge clk);
        #1;
        checks++;
        if (level !== 4'd1) begin
          errors++; $display("FAIL single_write: got %0d want 1", level);
        end
      end
    join
    pop();
    checks++;
    if (q !== 8'h3C || level !== 4'd0) begin
      errors++; $display("FAIL single_pop: got q=%h lvl=%0d want 3c/0", q, level);
    end
  endtask

  task automatic test_nine();
    int ov0;
    ov0 = n_ovr;
    for (int i = 0; i < 9; i++) send_byte(8'h30 + 8'(i));
    checks++;
    if (level !== 4'd8) begin
      errors++; $display("FAIL nine_level: got %0d want 8", level);
    end
    checks++;
    if (n_ovr - ov0 !== 1) begin
      errors++; $display("FAIL nine_ovr: got %0d want 1", n_ovr - ov0);
    end
    for (int i = 0; i < 8; i++) begin
      pop();
      checks++;
      if (q !== 8'h30 + 8'(i)) begin
        errors++; $display("FAIL nine_pop%0d: got %h want %h", i, q, 8'h30 + 8'(i));
      end
    end
    pop();
    checks++;
    if (q !== 8'h37 || level !== 4'd0) begin
      errors++; $display("FAIL nine_empty: got q=%h lvl=%0d want 37/0", q, level);
    end
  endtask

  task automatic test_bad_stop();
    int fe0;
    logic [7:0] b;
    fe0 = n_ferr;
    b = 8'h55;
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(DIV);
    end
    rxd = 1'b0;
    idle(3 * DIV);
    rxd = 1'b1;
    idle(2 * DIV);
    checks++;
    if (n_ferr - fe0 !== 1) begin
      errors++; $display("FAIL badstop_ferr: got %0d want 1", n_ferr - fe0);
    end
    checks++;
    if (level !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL badstop_state: got lvl=%0d busy=%b want 0/0", level, busy);
    end
    send_byte(8'h41);
    pop();
    checks++;
    if (q !== 8'h41 || level !== 4'd0) begin
      errors++; $display("FAIL badstop_next: got q=%h lvl=%0d want 41/0", q, level);
    end
  endtask

  task automatic test_false_start();
    int fe0;
    fe0 = n_ferr;
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL false_busy: got %b want 1", busy);
    end
    idle(200);
    checks++;
    if (busy !== 1'b0 || level !== 4'd0 || n_ferr != fe0) begin
      errors++; $display("FAIL false_idle: got busy=%b lvl=%0d fe=%0d want 0/0/0",
                         busy, level, n_ferr - fe0);
    end
`ifdef UART_RX_MAJORITY_EN
    rxd = 1'b0;
    idle(DIV);
    rxd = 1'b1;
    idle(420);
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(9 * DIV - 421);
    pop();
    checks++;
    if (q !== 8'hFF || level !== 4'd0) begin
      errors++; $display("FAIL glitch_reject: got q=%h lvl=%0d want ff/0", q, level);
    end
`endif
  endtask

  task automatic test_pop_write();
    int ov0;
    for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i));
    ov0 = n_ovr;
    fork
      send_byte(8'h70);
      begin
        repeat (1142) @(posedge clk);
        #1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
      end
    join
    checks++;
    if (level !== 4'd8 || n_ovr != ov0) begin
      errors++; $display("FAIL popwr_level: got lvl=%0d ovr=%0d want 8/0", level, n_ovr - ov0);
    end
    checks++;
    if (q !== 8'h60) begin
      errors++; $display("FAIL popwr_q: got %h want 60", q);
    end
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checks++;
    if (level !== 4'd0 || q !== 8'h60) begin
      errors++; $display("FAIL flush: got lvl=%0d q=%h want 0/60", level, q);
    end
    send_byte(8'h71);
    pop();
    checks++;
    if (q !== 8'h71 || level !== 4'd0) begin
      errors++; $display("FAIL flush_next: got q=%h lvl=%0d want 71/0", q, level);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    send_byte(8'h22);
    b = 8'h5A;
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(DIV);
    end
    rxd = b[4];
    idle(DIV / 2);
    checks++;
    if (busy !== 1'b1 || level !== 4'd1) begin
      errors++; $display("FAIL mid_pre: got busy=%b lvl=%0d want 1/1", busy, level);
    end
    rst = 1'b1;
    idle(2);
    checks++;
    if (level !== 4'd0 || q !== 8'h00 || {ferr, ovr, busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset: got lvl=%0d q=%h flags=%b want 0/00/000",
                         level, q, {ferr, ovr, busy});
    end
    rst = 1'b0;
    rxd = 1'b1;
    idle(2 * DIV);
    send_byte(8'hA5);
    checks++;
    if (level !== 4'd1) begin
      errors++; $display("FAIL mid_level: got %0d want 1", level);
    end
    pop();
    checks++;
    if (q !== 8'hA5) begin
      errors++; $display("FAIL mid_data: got %h want a5", q);
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    rxd   = 1'b1;
    rd    = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    test_reset();
    test_single();
    test_nine();
    test_bad_stop();
    test_false_start();
    test_pop_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
